bp_port_sched: RTL
==================

// Module: bp_port_sched
// PURPOSE
//  Arbitrates the predictor table's single access port between front-end prediction lookups
//  and retire-time update writes (branch outcome + index).
//  Buffers updates in a small FIFO. Runs a post-reset init sweep that writes every table entry.
//  Sits between fetch/retire and the bht/tage table arrays; the tables see exactly one access per cycle.
// PARAMETERS
//  IDX_W       10  table index width; table has 2**IDX_W entries
//  QDEPTH      4   update FIFO depth (power of 2, >=2)
//  STARVE_MAX  8   cycles a queued update may be blocked by lookups before it forces the port
// PORTS
//  clk_i           in   1      clock
//  rst_i           in   1      reset, synchronous, active-high
//  lookup_valid_i  in   1      prediction lookup request this cycle
//  lookup_idx_i    in   IDX_W  lookup index
//  lookup_grant_o  out  1      lookup owns the table port this cycle
//  upd_valid_i     in   1      branch resolved, update offered
//  upd_idx_i       in   IDX_W  update index
//  upd_taken_i     in   1      resolved branch outcome
//  upd_ready_o     out  1      FIFO can accept an update this cycle
//  tbl_en_o        out  1      table access enable
//  tbl_we_o        out  1      1 = write (update or init), 0 = read (lookup)
//  tbl_init_o      out  1      write is init sweep; table stores weakly-not-taken
//  tbl_idx_o       out  IDX_W  table index
//  tbl_taken_o     out  1      outcome for update write (0 during init)
//  init_busy_o     out  1      init sweep in progress
// BEHAVIOUR
//  - Registers reset (sync, rst_i=1 at posedge): state=INIT, sweep_cnt=0, FIFO empty, starve_cnt=0.
//    Outputs are combinational from registered state and inputs.
//    With state INIT: init_busy_o=1, lookup_grant_o=0, upd_ready_o=0.
//  - INIT: every cycle tbl_en_o=1, tbl_we_o=1, tbl_init_o=1, tbl_idx_o=sweep_cnt, tbl_taken_o=0; sweep_cnt++.
//    The cycle with sweep_cnt==all-ones is the last; next state RUN.
//    Sweep takes exactly 2**IDX_W cycles. sweep_cnt is IDX_W bits wide, no wrap is ever used.
//  - RUN: upd_ready_o = !fifo_full. Push when upd_valid_i && upd_ready_o.
//    No enqueue while full, even if the head pops in the same cycle.
//  - RUN arbitration, per cycle:
//    - Update wins if FIFO non-empty && (!lookup_valid_i || force).
//      Result: pop head, tbl_we_o=1, tbl_idx_o/tbl_taken_o=head.
//    - Else lookup wins if lookup_valid_i: lookup_grant_o=1, tbl_we_o=0, tbl_idx_o=lookup_idx_i.
//    - Else tbl_en_o=0.
//    - tbl_init_o=0 in RUN.
//  - No bypass: an update accepted in cycle t is written at t+1 at the earliest.
//    Writes occur in FIFO (acceptance) order.
//  - Push and pop in the same cycle (not full): both take effect, occupancy unchanged.
//  - Reset mid-operation: FIFO flushed and queued updates are dropped (never written).
//    The sweep restarts at index 0.
//  - rst_i is sampled only at posedge; outputs in the reset cycle reflect pre-reset state.
// CONFIGURATION
//  BP_STARVE_GUARD_EN defined:
//   - starve_cnt (clog2(STARVE_MAX+1) bits) increments each RUN cycle the FIFO is non-empty and no pop occurs.
//   - Clears on pop, when the FIFO is empty, and on reset. Saturates at STARVE_MAX.
//   - force = (starve_cnt==STARVE_MAX). In a forced cycle lookup_grant_o=0 even if lookup_valid_i=1.
//  BP_STARVE_GUARD_EN undefined: force=0, no counter. Lookups always win.
//   Updates drain only on lookup-free cycles and may starve indefinitely.
// STRUCTURE
//  bp_pkg:
//   - typedef struct packed {logic [IDX_W-1:0] idx; logic taken;} bp_upd_t (parameterised via pkg localparam).
//   - enum sched_state_e {SCHED_INIT, SCHED_RUN}.
//  Sub-module bp_upd_fifo:
//   - Synchronous FIFO of bp_upd_t, QDEPTH entries, push/pop/full/empty/head.
//   - Pointers one bit wider than clog2(QDEPTH) for full/empty.
//  bp_port_sched holds the FSM, sweep counter, starvation counter and port mux.
// TESTING
//  1 IDX_W=4: release reset at t0, lookup_valid_i=1 -> tbl_we_o=1 with idx 0..15 at t0..t15.
//    lookup_grant_o=0 throughout; init_busy_o=0 and lookup_grant_o=1 at t16.
//  2 RUN, lookup_valid_i=0: upd idx=5 taken=1 accepted at t -> at t+1 tbl_we_o=1, idx=5, taken=1.
//    At t+2 tbl_en_o=0.
//  3 Guard off, QDEPTH=4, lookups every cycle: push idx 1,2,3,4 -> upd_ready_o=0 after 4th, no writes.
//    Drop lookup_valid_i -> writes idx 1,2,3,4 on 4 consecutive cycles, then upd_ready_o=1.
//  4 Guard on, STARVE_MAX=8, lookups every cycle: one update accepted at t -> written at t+9.
//    lookup_grant_o=0 at t+9 only; a second queued entry is written at t+18.
//  5 RUN with 3 queued and lookups blocking: assert rst_i at t -> init_busy_o=1 at t+1.
//    Sweep idx 0..2**IDX_W-1 follows and none of the 3 updates is ever written.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor table port scheduler.
// The default table geometry lives here; bp_port_sched may be built narrower via its IDX_W parameter.
package bp_pkg;

    localparam int BP_IDX_W = 10;

    typedef struct packed {
        logic [BP_IDX_W-1:0] idx;
        logic                taken;
    } bp_upd_t;

    typedef enum logic [0:0] {
        SCHED_INIT = 1'b0,
        SCHED_RUN  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/bp_port_sched_if.sv
// Request/grant and table-port bundle between fetch/retire (master) and bp_port_sched (slave).
interface bp_port_sched_if #(
    parameter int IDX_W = bp_pkg::BP_IDX_W
);

    logic             lookup_valid_i;
    logic [IDX_W-1:0] lookup_idx_i;
    logic             lookup_grant_o;

    logic             upd_valid_i;
    logic [IDX_W-1:0] upd_idx_i;
    logic             upd_taken_i;
    logic             upd_ready_o;

    logic             tbl_en_o;
    logic             tbl_we_o;
    logic             tbl_init_o;
    logic [IDX_W-1:0] tbl_idx_o;
    logic             tbl_taken_o;
    logic             init_busy_o;

    modport master (
        output lookup_valid_i, lookup_idx_i,
        output upd_valid_i, upd_idx_i, upd_taken_i,
        input  lookup_grant_o, upd_ready_o,
        input  tbl_en_o, tbl_we_o, tbl_init_o, tbl_idx_o, tbl_taken_o,
        input  init_busy_o
    );

    modport slave (
        input  lookup_valid_i, lookup_idx_i,
        input  upd_valid_i, upd_idx_i, upd_taken_i,
        output lookup_grant_o, upd_ready_o,
        output tbl_en_o, tbl_we_o, tbl_init_o, tbl_idx_o, tbl_taken_o,
        output init_busy_o
    );

endinterface

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates until the table port is free.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module bp_upd_fifo #(
    parameter int DATA_W = bp_pkg::BP_IDX_W + 1,
    parameter int QDEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(QDEPTH);

    logic [DATA_W-1:0] mem [QDEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // A push while full is refused even when the head leaves in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/bp_port_sched.sv
// Single-port arbiter for the bht/tage tables: init sweep after reset, then lookups vs queued updates.
// Optional starvation guard for queued updates is enabled by defining BP_STARVE_GUARD_EN.
module bp_port_sched
    import bp_pkg::*;
#(
    parameter int IDX_W      = BP_IDX_W,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    bp_port_sched_if.slave     bus
);

    localparam logic [0:0] ST_INIT = 1'(SCHED_INIT);
    localparam logic [0:0] ST_RUN  = 1'(SCHED_RUN);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    logic [0:0]       state;
    logic [IDX_W-1:0] sweep_cnt;

    upd_t             push_data;
    upd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             force_pop;

    assign push_data = '{idx: bus.upd_idx_i, taken: bus.upd_taken_i};

    bp_upd_fifo #(
        .DATA_W ($bits(upd_t)),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sweep writes every entry once; the all-ones index is the final init cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
        end else if (state == ST_INIT) begin
            if (sweep_cnt == '1) begin
                state <= ST_RUN;
            end else begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

`ifdef BP_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [SC_W-1:0] starve_cnt;

    assign force_pop = (starve_cnt == SC_W'(STARVE_MAX));

    // Counts cycles the head has waited behind lookups; any pop or an empty queue restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if ((state == ST_RUN) && !fifo_empty && !pop) begin
            if (!force_pop) starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end
`else
    // No guard: lookups always take the port; the comparison is constant-false.
    assign force_pop = (STARVE_MAX < 0);
`endif

    always_comb begin
        bus.lookup_grant_o = 1'b0;
        bus.upd_ready_o    = 1'b0;
        bus.tbl_en_o       = 1'b0;
        bus.tbl_we_o       = 1'b0;
        bus.tbl_init_o     = 1'b0;
        bus.tbl_idx_o      = '0;
        bus.tbl_taken_o    = 1'b0;
        bus.init_busy_o    = (state == ST_INIT);
        push               = 1'b0;
        pop                = 1'b0;

        if (state == ST_INIT) begin
            bus.tbl_en_o   = 1'b1;
            bus.tbl_we_o   = 1'b1;
            bus.tbl_init_o = 1'b1;
            bus.tbl_idx_o  = sweep_cnt;
        end else begin
            bus.upd_ready_o = !fifo_full;
            push            = bus.upd_valid_i && !fifo_full;

            // Queued updates take the port on lookup-free cycles or when starved.
            if (!fifo_empty && (!bus.lookup_valid_i || force_pop)) begin
                pop             = 1'b1;
                bus.tbl_en_o    = 1'b1;
                bus.tbl_we_o    = 1'b1;
                bus.tbl_idx_o   = head.idx;
                bus.tbl_taken_o = head.taken;
            end else if (bus.lookup_valid_i) begin
                bus.lookup_grant_o = 1'b1;
                bus.tbl_en_o       = 1'b1;
                bus.tbl_idx_o      = bus.lookup_idx_i;
            end
        end
    end

endmodule
